// File: rtl/memory_col_be.sv
// Single-port word memory with per-byte write enables and a one-deep response register.
// Every accepted request yields one response; out-of-range addresses answer with rsp_err.
module memory_col_be #(
  parameter int BYTES = 4,
  parameter int DEPTH = 12,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [AW-1:0]        req_addr,
  input  logic [BYTES-1:0]     req_be,
  input  logic [8*BYTES-1:0]   req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [8*BYTES-1:0]   rsp_rdata,
  output logic                 rsp_err
);

  localparam int DW = 8 * BYTES;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  // Handshake: a request is taken on a rising edge with req_valid && req_ready;
  // a response is retired on a rising edge with rsp_valid && rsp_ready.
  // The response slot frees up in the same cycle it is consumed.

  logic [DW-1:0] mem_q [DEPTH];
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q,   rsp_err_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          accept;
  logic          in_range;

  assign req_ready = !rsp_valid_q || rsp_ready;
  assign accept    = req_valid && req_ready;
  assign in_range  = {1'b0, req_addr} < DEPTH_C;

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = !in_range;
      rsp_rdata_d = '0;
      if (!req_we && in_range) rsp_rdata_d = mem_q[req_addr];
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Storage is deliberately unreset; rst_n only gates writes so contents survive reset.
  always_ff @(posedge clk) begin
    if (rst_n && accept && req_we && in_range) begin
      for (int k = 0; k < BYTES; k++) begin
        if (req_be[k]) mem_q[req_addr][8*k +: 8] <= req_wdata[8*k +: 8];
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/memory_col_be.md
MEMORY_COL_BE -- requirements
Module: memory_col_be

Interface
REQ-001 Parameter BYTES, default 4: number of 8-bit byte lanes per word (1..16).
REQ-002 Parameter DEPTH, default 12: number of words stored (2..1024); need not be a power of two.
REQ-003 Parameter AW, default $clog2(DEPTH): address width; SHALL be at least $clog2(DEPTH).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request this cycle.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  AW  word address.
REQ-010 req_be  input  BYTES  per-lane write enable; ignored for reads.
REQ-011 req_wdata  input  8*BYTES  write data; lane k = bits [8k+7:8k].
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  consumer accepts the response.
REQ-014 rsp_rdata  output  8*BYTES  read data; zero for write responses and error responses.
REQ-015 rsp_err  output  1  request addressed a word >= DEPTH.

Function
REQ-016 Request is accepted on a rising edge where req_valid && req_ready.
REQ-017 req_ready SHALL be combinational: !rsp_valid || rsp_ready (back-to-back accepts at one per cycle while rsp_ready=1).
REQ-018 Every accepted request, read or write, SHALL produce exactly one response; responses in acceptance order.
REQ-019 Latency: rsp_valid SHALL assert on the edge that accepts the request (visible the following cycle).
REQ-020 Response register holds rsp_valid/rsp_rdata/rsp_err stable while rsp_valid && !rsp_ready.
REQ-021 On an edge where a response is consumed and no new request accepted, rsp_valid SHALL clear.
REQ-022 Write with addr < DEPTH: on the accept edge, lanes with req_be[k]=1 take req_wdata lane k; other lanes unchanged.
REQ-023 Write with req_be all zero: storage unchanged; response still issued with rsp_err=0.
REQ-024 Read with addr < DEPTH: rsp_rdata = word contents before the accept edge.
REQ-025 A read accepted the cycle after a write to the same address SHALL return the written data (no stale read).
REQ-026 addr >= DEPTH: write ignored, read not performed; response has rsp_err=1, rsp_rdata=0.
REQ-027 req_* inputs are don't-care when req_valid=0; no storage change when not accepted.
REQ-028 Storage contents are not reset; reading a never-written word returns an unspecified value without X-propagation into rsp_valid/rsp_err.

Reset
REQ-029 While rst_n=0: rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=1 (combinational from rsp_valid=0).
REQ-030 Reset asserted mid-operation SHALL drop any pending response immediately; requests presented during reset are not accepted and do not write storage.
REQ-031 Storage contents written before a reset SHALL be retained through reset.
REQ-032 First accept possible on the first rising edge after rst_n deasserts.

Verification
REQ-033 Full write then read: write addr 3, be=4'hF, data 32'hDEADBEEF; read addr 3 -> rsp_rdata=32'hDEADBEEF, rsp_err=0, one response per request.
REQ-034 Byte-lane merge: addr 5 holds 32'h11223344; write be=4'b0101, data 32'hAABBCCDD -> read returns 32'h11BB33DD.
REQ-035 Backpressure: hold rsp_ready=0 after a read of addr 3 -> req_ready=0, rsp_rdata stays 32'hDEADBEEF stable for 5 cycles; raise rsp_ready -> next queued request accepted same cycle.
REQ-036 Out of range (DEPTH=12): write addr 13 data 32'hFFFFFFFF, then read addr 13 -> both rsp_err=1, rsp_rdata=0; addr 0..11 unchanged.
REQ-037 Reset mid-stream: rst_n low with rsp_valid=1 -> rsp_valid=0 asynchronously, req_ready=1; after release, read addr 3 -> 32'hDEADBEEF.
REQ-038 Random soak: 1000 random requests (random addr 0..15, be, we, rsp_ready) checked against a reference model for data, rsp_err and response count.
